q_run_monitor: RTL and testbench



---
 rtl/q_run_monitor_pkg.sv | 23 ++
 rtl/q_run_monitor_if.sv | 14 +
 rtl/q_run_monitor_sync_fifo.sv | 50 +++++
 rtl/q_run_monitor.sv | 113 +++++++++++
 tb/tb_q_run_monitor.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/q_run_monitor_pkg.sv
// Shared types, defaults and helpers for the Q run-length monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package q_run_pkg;

    localparam int CNT_W_DEF      = 16;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int REC_W          = CNT_W_DEF + 1;

    // One completed run: the level Q held and how many samples it lasted.
    typedef struct packed {
        logic                 level;
        logic [CNT_W_DEF-1:0] len;
    } run_rec_t;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (cnt >= max_v) ? max_v : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/q_run_monitor_if.sv
// Run-record stream between the monitor and its consumer.
// Latency: n/a (wiring only).
// Backpressure: consumer holds run_ready low to stall; head stays stable.
interface q_run_monitor_if import q_run_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF
);
    logic             run_valid;
    logic             run_ready;
    logic             run_level;
    logic [CNT_W-1:0] run_len;

    modport master (output run_valid, output run_level, output run_len, input  run_ready);
    modport slave  (input  run_valid, input  run_level, input  run_len, output run_ready);
endinterface

// File: rtl/q_run_monitor_sync_fifo.sv
// Show-ahead synchronous FIFO holding run records.
// Latency: a push is visible at the head one clock after it is written.
// Backpressure: push on full is refused unless a pop happens that same cycle.
module sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_dat,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head_dat,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_pop_ok;
    logic             w_push_ok;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign o_level    = r_wr_ptr - r_rd_ptr;
    assign o_empty    = (o_level == '0);
    assign o_full     = (o_level == (AW+1)'(DEPTH));
    assign w_pop_ok   = i_pop & ~o_empty;
    assign w_push_ok  = i_push & (~o_full | w_pop_ok);
    assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

    // Storage needs no reset: contents are only ever read between the pointers.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end

    // Pointer advance; both wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/q_run_monitor.sv
// Measures each completed constant-level run of Q and streams {level, len} records.
// Latency: record visible one clock after the edge that ends its run; pulses likewise.
// Backpressure: run_ready stalls the head; records arriving while full are dropped and flagged.
module q_run_monitor import q_run_pkg::*; #(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          q_in,
    q_run_monitor_if.master               run_if,
    output logic                          rise_pulse,
    output logic                          fall_pulse,
    output logic                          ovf_sticky,
    input  logic                          ovf_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int REC_BITS = CNT_W + 1;

    typedef struct packed {
        logic             level;
        logic [CNT_W-1:0] len;
    } rec_t;

    logic             r_q_d;
    logic             r_armed;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rise;
    logic             r_fall;
    logic             r_ovf;

    logic             w_edge;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;
    logic [CNT_W-1:0] w_cnt_inc;
    rec_t             w_push_rec;
    rec_t             w_head_rec;

    assign w_edge     = q_in ^ r_q_d;
    assign w_push     = en & r_armed & w_edge;
    assign w_pop      = ~w_empty & run_if.run_ready;
    assign w_drop     = w_push & w_full & ~w_pop;
    assign w_cnt_inc  = CNT_W'(sat_inc(32'(r_cnt), CNT_W));
    assign w_push_rec = {r_q_d, r_cnt};

    // Previous Q sample; tracked even while disabled so re-enable sees true edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_q_d <= 1'b0;
        else     r_q_d <= q_in;
    end

    // Arming and run counting; the first run after reset/enable has no known start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed <= 1'b0;
            r_cnt   <= '0;
        end else if (!en) begin
            r_armed <= 1'b0;
            r_cnt   <= '0;
        end else if (w_edge) begin
            r_armed <= 1'b1;
            r_cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (r_armed) begin
            r_cnt   <= w_cnt_inc;
        end
    end

    // Edge pulses follow every recorded edge, including ones whose record is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_push & q_in;
            r_fall <= w_push & ~q_in;
        end
    end

    // Overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_ovf <= 1'b0;
        else if (w_drop)  r_ovf <= 1'b1;
        else if (ovf_clr) r_ovf <= 1'b0;
    end

    sync_fifo #(
        .WIDTH (REC_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dat (w_push_rec),
        .i_pop      (run_if.run_ready),
        .o_head_dat (w_head_rec),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_level    (fifo_level)
    );

    // Head fields read as zero while empty so nothing stale is ever presented.
    assign run_if.run_valid = ~w_empty;
    assign run_if.run_level = w_head_rec.level & ~w_empty;
    assign run_if.run_len   = w_empty ? '0 : w_head_rec.len;
    assign rise_pulse       = r_rise;
    assign fall_pulse       = r_fall;
    assign ovf_sticky       = r_ovf;

endmodule

// File: tb/tb_q_run_monitor.sv
// Directed bench for q_run_monitor: a CNT_W=16 instance plus a CNT_W=4 instance for saturation.
// Inputs change 1 time unit after the rising edge; outputs are checked there or at the falling edge.
// Popped records and edge pulses are logged at the falling edge and compared against hand-worked values.
module tb_q_run_monitor;
    import q_run_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic q_in;
    logic ovf_clr;

    logic       rise,  fall,  ovf;
    logic       rise4, fall4, ovf4;
    logic [2:0] lvl,   lvl4;

    int n_chk  = 0;
    int n_pass = 0;
    int n_rise = 0;
    int n_fall = 0;

    run_rec_t   popq [$];
    logic [REC_W-1:0] pop_bits;
    bit seq1 [0:14] = '{0,0,0,1,1,1,1,1,0,0,1,1,1,1,0};

    always #5 clk = ~clk;

    q_run_monitor_if #(.CNT_W(16)) rif  ();
    q_run_monitor_if #(.CNT_W(4))  rif4 ();

    q_run_monitor #(.CNT_W(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .q_in(q_in), .run_if(rif),
        .rise_pulse(rise), .fall_pulse(fall), .ovf_sticky(ovf),
        .ovf_clr(ovf_clr), .fifo_level(lvl)
    );

    q_run_monitor #(.CNT_W(4), .FIFO_DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .q_in(q_in), .run_if(rif4),
        .rise_pulse(rise4), .fall_pulse(fall4), .ovf_sticky(ovf4),
        .ovf_clr(ovf_clr), .fifo_level(lvl4)
    );

    // Log every accepted record and every pulse of the 16-bit instance.
    always @(negedge clk) begin
        if (rif.run_valid && rif.run_ready) begin
            pop_bits = {rif.run_level, rif.run_len};
            popq.push_back(run_rec_t'(pop_bits));
        end
        if (rise) n_rise++;
        if (fall) n_fall++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic chk_rec(input string tag, input int idx, input int lv, input int ln);
        if (idx < popq.size()) begin
            chk({tag, ".level"}, 32'(popq[idx].level), lv);
            chk({tag, ".len"},   32'(popq[idx].len),   ln);
        end else begin
            chk({tag, ".present"}, popq.size(), idx + 1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        q_in = 1'b0;
        ovf_clr = 1'b0;
        en = 1'b0;
        rif.run_ready = 1'b0;
        rif4.run_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base, r0, f0;
        rst = 1'b1; en = 1'b0; q_in = 1'b0; ovf_clr = 1'b0;
        rif.run_ready = 1'b0; rif4.run_ready = 1'b0;
        #2;
        chk("rst.valid", 32'(rif.run_valid), 0);
        chk("rst.len",   32'(rif.run_len),   0);
        chk("rst.level", 32'(rif.run_level), 0);
        chk("rst.flvl",  32'(lvl),           0);
        chk("rst.rise",  32'(rise),          0);
        chk("rst.fall",  32'(fall),          0);
        chk("rst.ovf",   32'(ovf),           0);
        tick();
        rst = 1'b0;

        // Basic runs: 0x3 1x5 0x2 1x4 0 -> {1,5} {0,2} {1,4}
        base = popq.size(); r0 = n_rise; f0 = n_fall;
        en = 1'b1; rif.run_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            q_in = seq1[i];
            tick();
            if (i == 3) chk("t1.arm_nopulse", 32'(rise), 0);
            if (i == 8) begin
                chk("t1.valid", 32'(rif.run_valid), 1);
                chk("t1.level", 32'(rif.run_level), 1);
                chk("t1.len",   32'(rif.run_len),   5);
                chk("t1.fall",  32'(fall),          1);
                chk("t1.flvl",  32'(lvl),           1);
            end
            if (i == 10) begin
                chk("t1.len2", 32'(rif.run_len), 2);
                chk("t1.rise", 32'(rise),        1);
            end
        end
        repeat (3) tick();
        chk("t1.count", popq.size() - base, 3);
        chk_rec("t1.r0", base + 0, 1, 5);
        chk_rec("t1.r1", base + 1, 0, 2);
        chk_rec("t1.r2", base + 2, 1, 4);
        chk("t1.nrise", n_rise - r0, 1);
        chk("t1.nfall", n_fall - f0, 2);
        chk("t1.empty", 32'(lvl), 0);

        // Overflow: runs of 3 with no consumer, then full-FIFO push+pop and clear cases.
        do_reset();
        base = popq.size();
        en = 1'b1;
        for (int b = 1; b <= 7; b++) begin
            for (int c = 0; c < 3; c++) begin
                q_in = (b % 2 == 1);
                ovf_clr = (b == 7 && c == 1);
                tick();
                if (b == 5 && c == 0) begin
                    chk("t2.full", 32'(lvl), 4);
                    chk("t2.noovf", 32'(ovf), 0);
                end
                if (b == 6 && c == 0) begin
                    chk("t2.flvl", 32'(lvl),  4);
                    chk("t2.ovf",  32'(ovf),  1);
                    chk("t2.dropfall", 32'(fall), 1);
                end
                if (b == 7 && c == 1) chk("t2.clr", 32'(ovf), 0);
            end
        end
        ovf_clr = 1'b0;
        q_in = 1'b0; rif.run_ready = 1'b1;
        tick();
        chk("t3.flvl", 32'(lvl),  4);
        chk("t3.ovf",  32'(ovf),  0);
        chk("t3.fall", 32'(fall), 1);
        q_in = 1'b1; rif.run_ready = 1'b0; ovf_clr = 1'b1;
        tick();
        chk("t7.clr_drop_ovf", 32'(ovf),  1);
        chk("t7.flvl",         32'(lvl),  4);
        chk("t7.rise",         32'(rise), 1);
        ovf_clr = 1'b0; rif.run_ready = 1'b1;
        repeat (6) tick();
        chk("t2.count", popq.size() - base, 5);
        chk_rec("t2.r0", base + 0, 1, 3);
        chk_rec("t2.r1", base + 1, 0, 3);
        chk_rec("t2.r2", base + 2, 1, 3);
        chk_rec("t2.r3", base + 3, 0, 3);
        chk_rec("t2.r4", base + 4, 1, 3);
        chk("t2.drained", 32'(lvl),           0);
        chk("t2.novalid", 32'(rif.run_valid), 0);

        // Saturation: 21 high samples -> 21 on the 16-bit counter, 15 on the 4-bit one.
        do_reset();
        en = 1'b1; rif.run_ready = 1'b1;
        q_in = 1'b1;
        tick();
        repeat (20) tick();
        q_in = 1'b0;
        tick();
        chk("t4.valid4", 32'(rif4.run_valid), 1);
        chk("t4.level4", 32'(rif4.run_level), 1);
        chk("t4.sat4",   32'(rif4.run_len),   15);
        chk("t4.fall4",  32'(fall4),          1);
        chk("t4.len16",  32'(rif.run_len),    21);

        // Enable dropped mid-run: that run is lost; next full run is reported correctly.
        do_reset();
        base = popq.size(); r0 = n_rise; f0 = n_fall;
        en = 1'b1; rif.run_ready = 1'b1;
        q_in = 1'b1; tick();
        tick(); tick();
        en = 1'b0; tick();
        q_in = 1'b0; tick();
        chk("t5.dis_fall", 32'(fall), 0);
        chk("t5.dis_flvl", 32'(lvl),  0);
        en = 1'b1; tick(); tick();
        q_in = 1'b1; tick();
        chk("t5.rearm_rise", 32'(rise), 0);
        repeat (3) tick();
        q_in = 1'b0; tick();
        repeat (2) tick();
        chk("t5.count", popq.size() - base, 1);
        chk_rec("t5.r0", base, 1, 4);
        chk("t5.nrise", n_rise - r0, 0);
        chk("t5.nfall", n_fall - f0, 1);

        // Asynchronous reset with three records queued.
        do_reset();
        base = popq.size();
        en = 1'b1;
        q_in = 1'b1; tick();
        tick();
        q_in = 1'b0; tick();
        q_in = 1'b1; tick();
        q_in = 1'b0; tick();
        chk("t6.queued", 32'(lvl), 3);
        #3 rst = 1'b1;
        #1;
        chk("t6.async_valid", 32'(rif.run_valid), 0);
        chk("t6.async_flvl",  32'(lvl),           0);
        @(posedge clk);
        #1 rst = 1'b0;
        rif.run_ready = 1'b1;
        q_in = 1'b1; tick();
        chk("t6.arm_valid", 32'(rif.run_valid), 0);
        tick();
        chk("t6.run_valid", 32'(rif.run_valid), 0);
        q_in = 1'b0; tick();
        chk("t6.valid", 32'(rif.run_valid), 1);
        chk("t6.level", 32'(rif.run_level), 1);
        chk("t6.len",   32'(rif.run_len),   2);
        tick();
        chk("t6.count", popq.size() - base, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
